// File: rtl/data_memory_unit.sv
// Word-addressed data memory: fixed-latency load handshake, single-cycle stores and a
// 1-entry write buffer for stores arriving mid-load. Define DMEM_STATS_EN for access counters.
module data_memory_unit #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memAddrLoadStore,
  input  logic [DATA_W-1:0] memStoreVal,
  input  logic              writeReq,
  input  logic              readReq,
  output logic [DATA_W-1:0] memLoadVal,
  output logic              valueReady,
  output logic              busy,
  output logic              errOverflow
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       readCount,
  output logic [15:0]       writeCount
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                rearm_reg;
  logic                wb_valid_reg;
  logic [ADDR_W-1:0]   wb_addr_reg;
  logic [DATA_W-1:0]   wb_data_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, load_fire, in_idle;
  logic                drain, direct_wr, buf_wr, drop_wr, mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   load_data;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    load_fire  = 1'b0;
    case (state_reg)
      IDLE: if (readReq && rearm_reg) begin
        state_next = BUSY;
        accept     = 1'b1;
      end
      BUSY: if (cnt_reg == 4'd1) begin
        state_next = DONE;
        load_fire  = 1'b1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer drain wins the memory port in IDLE; a store arriving on that same edge refills the buffer.
  always_comb begin
    in_idle   = (state_reg == IDLE);
    drain     = in_idle && wb_valid_reg;
    direct_wr = in_idle && !wb_valid_reg && writeReq;
    buf_wr    = writeReq && (in_idle ? wb_valid_reg : !wb_valid_reg);
    drop_wr   = writeReq && !in_idle && wb_valid_reg;
    mem_we    = drain || direct_wr;
    mem_waddr = drain ? wb_addr_reg : memAddrLoadStore;
    mem_wdata = drain ? wb_data_reg : memStoreVal;
  end

  // Forward the newest pending store to the in-flight address, including one captured this edge.
  always_comb begin
    if (wb_valid_reg && wb_addr_reg == addr_reg)
      load_data = wb_data_reg;
    else if (buf_wr && memAddrLoadStore == addr_reg)
      load_data = memStoreVal;
    else
      load_data = mem[addr_reg];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      rearm_reg    <= 1'b1;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      memLoadVal   <= '0;
      errOverflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= memAddrLoadStore;
        cnt_reg  <= CNT_INIT;
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      if (load_fire)
        memLoadVal <= load_data;
      if (!readReq)
        rearm_reg <= 1'b1;
      else if (state_reg == DONE)
        rearm_reg <= 1'b0;
      if (buf_wr) begin
        wb_valid_reg <= 1'b1;
        wb_addr_reg  <= memAddrLoadStore;
        wb_data_reg  <= memStoreVal;
      end else if (drain) begin
        wb_valid_reg <= 1'b0;
      end
      if (drop_wr)
        errOverflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign valueReady = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readCount  <= 16'd0;
      writeCount <= 16'd0;
    end else begin
      if (valueReady && readCount != 16'hFFFF)
        readCount <= readCount + 16'd1;
      if (mem_we && writeCount != 16'hFFFF)
        writeCount <= writeCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Bench for data_memory_unit: directed scenarios plus randomized loads/stores against a
// transaction-level memory model. Counter checks are active when DMEM_STATS_EN is defined.
module tb_data_memory_unit;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  memAddrLoadStore = 8'd0;
  logic [15:0] memStoreVal = 16'd0;
  logic        writeReq = 1'b0;
  logic        readReq = 1'b0;
  logic [15:0] memLoadVal;
  logic        valueReady;
  logic        busy;
  logic        errOverflow;
`ifdef DMEM_STATS_EN
  logic [15:0] readCount;
  logic [15:0] writeCount;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] model_mem [256];
  logic        model_err = 1'b0;
  int          model_reads = 0;
  int          model_writes = 0;

  data_memory_unit #(.DATA_W(16), .ADDR_W(8), .READ_LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .memAddrLoadStore (memAddrLoadStore),
    .memStoreVal      (memStoreVal),
    .writeReq         (writeReq),
    .readReq          (readReq),
    .memLoadVal       (memLoadVal),
    .valueReady       (valueReady),
    .busy             (busy),
    .errOverflow      (errOverflow)
`ifdef DMEM_STATS_EN
    ,
    .readCount        (readCount),
    .writeCount       (writeCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef DMEM_STATS_EN
    chk({tag, "_readCount"}, 32'(readCount), 32'(model_reads));
    chk({tag, "_writeCount"}, 32'(writeCount), 32'(model_writes));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store_idle(input logic [7:0] a, input logic [15:0] d);
    memAddrLoadStore = a;
    memStoreVal      = d;
    writeReq         = 1'b1;
    tick();
    writeReq         = 1'b0;
    model_mem[a]     = d;
    model_writes++;
  endtask

  // One load transaction. se: store to the same address on the accepting edge.
  // i1c/i2c: cycle offset (0..LAT-1, -1 = none) at which a store is issued mid-load.
  task automatic do_load(input string tag, input logic [7:0] a, input bit hold,
                         input bit se, input logic [15:0] sd,
                         input int i1c, input logic [7:0] i1a, input logic [15:0] i1d,
                         input int i2c, input logic [7:0] i2a, input logic [15:0] i2d);
    logic [15:0] exp;
    bit          pend;
    logic [7:0]  pa;
    logic [15:0] pd;
    memAddrLoadStore = a;
    readReq          = 1'b1;
    if (se) begin
      writeReq     = 1'b1;
      memStoreVal  = sd;
      model_mem[a] = sd;
      model_writes++;
    end
    tick();
    writeReq = 1'b0;
    exp  = model_mem[a];
    pend = 1'b0;
    pa   = 8'd0;
    pd   = 16'd0;
    for (int c = 0; c <= LAT; c++) begin
      chk({tag, "_valueReady"}, 32'(valueReady), 32'(c == LAT - 1));
      chk({tag, "_busy"}, 32'(busy), 32'(c <= LAT - 1));
      if (c == LAT - 1) begin
        chk({tag, "_memLoadVal"}, 32'(memLoadVal), 32'(exp));
        model_reads++;
        if (!hold) readReq = 1'b0;
      end
      writeReq = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (c == (k == 0 ? i1c : i2c)) begin
          writeReq         = 1'b1;
          memAddrLoadStore = (k == 0) ? i1a : i2a;
          memStoreVal      = (k == 0) ? i1d : i2d;
          if (!pend) begin
            pend = 1'b1;
            pa   = memAddrLoadStore;
            pd   = memStoreVal;
            if (pa == a && c <= LAT - 2) exp = pd;
          end else begin
            model_err = 1'b1;
          end
        end
      end
      tick();
    end
    tick();
    if (pend) begin
      model_mem[pa] = pd;
      model_writes++;
    end
    chk({tag, "_errOverflow"}, 32'(errOverflow), 32'(model_err));
    chk_stats(tag);
    $display("load %s addr=%h data=%h", tag, a, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valueReady", 32'(valueReady), 32'd0);
    chk("rst_memLoadVal", 32'(memLoadVal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errOverflow", 32'(errOverflow), 32'd0);
    chk_stats("rst");
    rst = 1'b1;
    tick();

    for (int a = 0; a < 256; a++) store_idle(8'(a), 16'($urandom));
    chk_stats("preload");

    // Basic write then load with fixed latency
    store_idle(8'h10, 16'hBEEF);
    do_load("t1_beef", 8'h10, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);

    // readReq held across completion must not start another load
    do_load("t2_hold", 8'h10, 1'b1, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      chk("t2_no_repulse", 32'(valueReady), 32'd0);
      chk("t2_idle_busy", 32'(busy), 32'd0);
      tick();
    end
    readReq = 1'b0;
    tick();
    do_load("t2_rearm", 8'h33, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);

    // Store to the in-flight address is forwarded, then drains to memory
    do_load("t3_fwd", 8'h20, 1'b0, 1'b0, 16'h0, 0, 8'h20, 16'h1234, -1, 8'h0, 16'h0);
    do_load("t3_after", 8'h20, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);

    // Two stores in one load window: second dropped, errOverflow sticky
    do_load("t4_ovf", 8'h40, 1'b0, 1'b0, 16'h0, 0, 8'h41, 16'h5151, 1, 8'h42, 16'h5252);
    do_load("t4_kept", 8'h41, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);
    do_load("t4_lost", 8'h42, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);
    repeat (5) begin
      chk("t4_sticky", 32'(errOverflow), 32'd1);
      tick();
    end

    // Same-edge store and load to one address
    do_load("t5_same_edge", 8'h05, 1'b0, 1'b1, 16'h00AA, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      logic [7:0]  ra;
      logic [7:0]  oa;
      logic [15:0] d;
      int          kind;
      int          ic;
      ra   = 8'($urandom);
      oa   = ra + 8'($urandom_range(1, 200));
      d    = 16'($urandom);
      kind = $urandom_range(0, 4);
      ic   = $urandom_range(0, LAT - 1);
      if ($urandom_range(0, 1) == 1) store_idle(8'($urandom), 16'($urandom));
      case (kind)
        0: do_load("rnd_plain", ra, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);
        1: do_load("rnd_fwd", ra, 1'b0, 1'b0, 16'h0, ic, ra, d, -1, 8'h0, 16'h0);
        2: do_load("rnd_other", ra, 1'b0, 1'b0, 16'h0, ic, oa, d, -1, 8'h0, 16'h0);
        3: do_load("rnd_same_edge", ra, 1'b0, 1'b1, d, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);
        default: do_load("rnd_ovf", ra, 1'b0, 1'b0, 16'h0, 0, oa, d, LAT - 1, ra, ~d);
      endcase
    end

    // Reset mid-load: no pulse, buffered store discarded
    memAddrLoadStore = 8'h60;
    readReq = 1'b1;
    tick();
    writeReq = 1'b1;
    memAddrLoadStore = 8'h61;
    memStoreVal = ~model_mem[8'h61];
    tick();
    writeReq = 1'b0;
    readReq = 1'b0;
    rst = 1'b0;
    #1;
    model_err = 1'b0;
    model_reads = 0;
    model_writes = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_valueReady", 32'(valueReady), 32'd0);
    chk("t6_errOverflow", 32'(errOverflow), 32'd0);
    chk("t6_memLoadVal", 32'(memLoadVal), 32'd0);
    chk_stats("t6_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2 * LAT; i++) begin
      chk("t6_no_pulse", 32'(valueReady), 32'd0);
      tick();
    end
    do_load("t6_discarded", 8'h61, 1'b0, 1'b0, 16'h0, -1, 8'h0, 16'h0, -1, 8'h0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
